// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for the single-port 1024x32 on-chip RAM.
// Master A fetches instructions and only reads. Master B reads and writes data.
module onchip_mem_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned MAX_CONSEC    = 4,
  parameter int unsigned ADDR_W        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_read,
  input  logic [ADDR_W-1:0] a_address,
  output logic              a_waitrequest,
  output logic [31:0]       a_readdata,
  output logic              a_readdatavalid,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [3:0]        b_byteenable,
  input  logic [31:0]       b_writedata,
  output logic              b_waitrequest,
  output logic [31:0]       b_readdata,
  output logic              b_readdatavalid,
  input  logic              freeze,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

  gnt_e             last_gnt;
  logic [CNT_W-1:0] consec_cnt;
  logic             rdv_a;
  logic             rdv_b;
  logic             req_a;
  logic             req_b;
  logic             gnt_a;
  logic             gnt_b;

  // Same-cycle arbitration; reset and freeze block every grant
  always_comb begin
    req_a = a_read;
    req_b = b_read | b_write;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!(reset || freeze)) begin
      if (req_a && req_b) begin
        if (PRIORITY_MODE == 0) begin
          gnt_a = (last_gnt == GNT_B);
        end else begin
          gnt_a = (consec_cnt != CNT_MAX);
        end
        gnt_b = ~gnt_a;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  assign a_waitrequest = ~gnt_a;
  assign b_waitrequest = ~gnt_b;

  // RAM command follows the winner; an idle bus parks on A's address
  assign mem_address    = gnt_b ? b_address : a_address;
  assign mem_byteenable = gnt_b ? b_byteenable : 4'hF;
  assign mem_chipselect = gnt_a | gnt_b;
  assign mem_write      = gnt_b & b_write;
  assign mem_writedata  = gnt_b ? b_writedata : 32'h0;

  // RAM q is shared; the valid flags tell each master when it is theirs
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;
  assign a_readdatavalid = rdv_a;
  assign b_readdatavalid = rdv_b;

  // Fairness state and one-cycle read latency tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= GNT_B;
      consec_cnt <= '0;
      rdv_a      <= 1'b0;
      rdv_b      <= 1'b0;
    end else begin
      rdv_a <= gnt_a;
      rdv_b <= gnt_b & b_read & ~b_write;
      if (gnt_a) begin
        last_gnt <= GNT_A;
      end else if (gnt_b) begin
        last_gnt <= GNT_B;
      end
      if (gnt_b || !req_b) begin
        consec_cnt <= '0;
      end else if (gnt_a && (consec_cnt != CNT_MAX)) begin
        consec_cnt <= consec_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus.
// Each instance has its own RAM and is checked against a rule-level model.
module tb_onchip_mem_arbiter;

  localparam int MAXC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_read;
  logic [9:0]  a_address;
  logic        b_read;
  logic        b_write;
  logic [9:0]  b_address;
  logic [3:0]  b_byteenable;
  logic [31:0] b_writedata;
  logic        freeze;
  logic        load_mem;

  logic [1:0]  a_wait, a_rdv, b_wait, b_rdv, m_cs, m_wr;
  logic [31:0] a_rd [2];
  logic [31:0] b_rd [2];
  logic [31:0] m_wd [2];
  logic [31:0] m_rd [2];
  logic [9:0]  m_addr [2];
  logic [3:0]  m_be [2];

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = round-robin, 1 = fixed priority
  logic [31:0] ref_mem [2][1024];
  bit          last_b [2];
  int          streak [2];
  bit          p_a [2];
  bit          p_b [2];
  logic [9:0]  p_addr [2];
  logic [31:0] obs_ard [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1023) ? 32'h11223344 : 32'(i);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] ram [1024];
    logic [9:0]  ra;

    onchip_mem_arbiter #(
      .PRIORITY_MODE(k),
      .MAX_CONSEC   (MAXC),
      .ADDR_W       (10)
    ) dut (
      .clk            (clk),
      .reset          (reset),
      .a_read         (a_read),
      .a_address      (a_address),
      .a_waitrequest  (a_wait[k]),
      .a_readdata     (a_rd[k]),
      .a_readdatavalid(a_rdv[k]),
      .b_read         (b_read),
      .b_write        (b_write),
      .b_address      (b_address),
      .b_byteenable   (b_byteenable),
      .b_writedata    (b_writedata),
      .b_waitrequest  (b_wait[k]),
      .b_readdata     (b_rd[k]),
      .b_readdatavalid(b_rdv[k]),
      .freeze         (freeze),
      .mem_address    (m_addr[k]),
      .mem_byteenable (m_be[k]),
      .mem_chipselect (m_cs[k]),
      .mem_write      (m_wr[k]),
      .mem_writedata  (m_wd[k]),
      .mem_readdata   (m_rd[k])
    );

    // RAM: registered address, unregistered q, byte-lane writes
    always @(posedge clk) begin
      if (load_mem) begin
        for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
      end else if (m_cs[k] && m_wr[k]) begin
        for (int j = 0; j < 4; j++)
          if (m_be[k][j]) ram[m_addr[k]][8*j +: 8] <= m_wd[k][8*j +: 8];
      end
      ra <= m_addr[k];
    end
    assign m_rd[k] = ram[ra];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check at negedge, advance the model at posedge
  task automatic cycle(input logic ar, input logic [9:0] aa, input logic br, input logic bw,
                       input logic [9:0] ba, input logic [3:0] be, input logic [31:0] wd,
                       input logic fr, input logic rs);
    bit ga [2];
    bit gb [2];
    bit rb;
    a_read = ar; a_address = aa; b_read = br; b_write = bw; b_address = ba;
    b_byteenable = be; b_writedata = wd; freeze = fr; reset = rs;
    rb = br | bw;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs || fr) begin
        ga[k] = 0; gb[k] = 0;
      end else if (ar && rb) begin
        ga[k] = (k == 0) ? last_b[k] : (streak[k] != MAXC);
        gb[k] = !ga[k];
      end else begin
        ga[k] = ar; gb[k] = rb;
      end
      check($sformatf("m%0d_a_wait", k), 32'(a_wait[k]), 32'(!ga[k]));
      check($sformatf("m%0d_b_wait", k), 32'(b_wait[k]), 32'(!gb[k]));
      check($sformatf("m%0d_cs", k), 32'(m_cs[k]), 32'(ga[k] | gb[k]));
      check($sformatf("m%0d_wr", k), 32'(m_wr[k]), 32'(gb[k] & bw));
      check($sformatf("m%0d_addr", k), 32'(m_addr[k]), 32'(gb[k] ? ba : aa));
      if (ga[k] || gb[k]) check($sformatf("m%0d_be", k), 32'(m_be[k]), 32'(gb[k] ? be : 4'hF));
      if (gb[k] && bw) check($sformatf("m%0d_wd", k), m_wd[k], wd);
      check($sformatf("m%0d_a_rdv", k), 32'(a_rdv[k]), 32'(p_a[k]));
      check($sformatf("m%0d_b_rdv", k), 32'(b_rdv[k]), 32'(p_b[k]));
      if (p_a[k]) check($sformatf("m%0d_a_rd", k), a_rd[k], ref_mem[k][p_addr[k]]);
      if (p_b[k]) check($sformatf("m%0d_b_rd", k), b_rd[k], ref_mem[k][p_addr[k]]);
      obs_ard[k] = a_rd[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        last_b[k] = 1; streak[k] = 0; p_a[k] = 0; p_b[k] = 0;
      end else begin
        p_a[k] = ga[k];
        p_b[k] = gb[k] && br && !bw;
        p_addr[k] = gb[k] ? ba : aa;
        if (ga[k] || gb[k]) last_b[k] = gb[k];
        if (gb[k] || !rb) streak[k] = 0;
        else if (ga[k] && streak[k] < MAXC) streak[k]++;
        if (gb[k] && bw)
          for (int j = 0; j < 4; j++)
            if (be[j]) ref_mem[k][ba][8*j +: 8] = wd[8*j +: 8];
      end
    end
    #1;
  endtask

  task automatic idle(input logic fr, input logic rs);
    cycle(0, 10'h0, 0, 0, 10'h0, 4'h0, 32'h0, fr, rs);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(i);
      last_b[k] = 1; streak[k] = 0; p_a[k] = 0; p_b[k] = 0; p_addr[k] = '0;
    end
    load_mem = 1;
    idle(0, 1);
    idle(0, 1);
    load_mem = 0;
    idle(0, 1);

    // single A read of a preloaded word
    cycle(1, 10'h005, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0);
    idle(0, 0);
    check("a_rd_005_rr", obs_ard[0], 32'h00000005);
    check("a_rd_005_fp", obs_ard[1], 32'h00000005);

    // both masters reading continuously
    for (int i = 0; i < 6; i++)
      cycle(1, 10'(i), 1, 0, 10'(100 + i), 4'hF, 32'h0, 0, 0);
    idle(0, 0);

    // partial write then read-back of the top word
    cycle(0, 10'h0, 0, 1, 10'h3FF, 4'b0011, 32'hDEADBEEF, 0, 0);
    cycle(1, 10'h3FF, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0);
    idle(0, 0);
    check("a_rd_3ff_rr", obs_ard[0], 32'h1122BEEF);
    check("a_rd_3ff_fp", obs_ard[1], 32'h1122BEEF);

    // long contention window exposes the starvation limit
    for (int i = 0; i < 12; i++)
      cycle(1, 10'(20 + i), 1, 0, 10'(40 + i), 4'hF, 32'h0, 0, 0);
    idle(0, 0);

    // read and write together counts as a write
    cycle(0, 10'h0, 1, 1, 10'h010, 4'hF, 32'h0000CAFE, 0, 0);
    cycle(1, 10'h010, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0);
    idle(0, 0);
    check("a_rd_010_rr", obs_ard[0], 32'h0000CAFE);
    check("a_rd_010_fp", obs_ard[1], 32'h0000CAFE);

    // read requested while reset is high, then reset right after a grant
    cycle(1, 10'h007, 0, 0, 10'h0, 4'h0, 32'h0, 0, 1);
    idle(0, 0);
    cycle(1, 10'h008, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0);
    idle(0, 1);
    idle(0, 0);

    // freeze right after a grant lets the read finish but blocks new ones
    cycle(1, 10'h009, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 10'h00A, 1, 0, 10'h00B, 4'hF, 32'h0, 1, 0);
    cycle(1, 10'h00A, 1, 0, 10'h00B, 4'hF, 32'h0, 0, 0);
    idle(0, 0);

    // random traffic over a small address window
    for (int i = 0; i < 600; i++) begin
      logic ar, br, bw, fr, rs;
      logic [9:0] aa, ba;
      ar = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 2) != 0);
      bw = ($urandom_range(0, 2) == 0);
      fr = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 49) == 0);
      aa = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      ba = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      cycle(ar, aa, br, bw, ba, 4'($urandom_range(0, 15)), $urandom, fr, rs);
    end
    idle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master arbiter in front of the 1024x32 single-port on-chip RAM (altsyncram, registered address, unregistered q, byte enables).
- Master A is the instruction-fetch port and is read-only. Master B is the data port and does reads and writes.
- Grants at most one access per cycle, tracks the one-cycle read latency, and returns readdatavalid to the right master.
- Fairness is round-robin, or fixed priority with a starvation limit.

Parameters:
- PRIORITY_MODE, 0: 0 = round-robin; 1 = fixed priority to A, subject to MAX_CONSEC.
- MAX_CONSEC, 4: in mode 1, the maximum number of consecutive A grants while B is waiting (range 1..15).
- ADDR_W, 10: word address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_read  in  1  master A read request
- a_address  in  ADDR_W  master A word address
- a_waitrequest  out  1  high = A command not accepted this cycle
- a_readdata  out  32  A read data
- a_readdatavalid  out  1  A read data valid
- b_read  in  1  master B read request
- b_write  in  1  master B write request
- b_address  in  ADDR_W  master B word address
- b_byteenable  in  4  master B byte lanes
- b_writedata  in  32  master B write data
- b_waitrequest  out  1  high = B command not accepted this cycle
- b_readdata  out  32  B read data
- b_readdatavalid  out  1  B read data valid
- freeze  in  1  high = issue no new grants
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  4  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  32  to RAM writedata
- mem_readdata  in  32  from RAM q, valid the cycle after the address is presented

Behaviour:
- Request terms:
  - reqA = a_read.
  - reqB = b_read | b_write. If both b_read and b_write are high, the access is a write and no readdatavalid is produced.
- Grant is combinational in cycle N: gntA / gntB = arbitration(reqA, reqB, last_gnt, consec_cnt). Both grants are forced 0 when reset or freeze is high.
- a_waitrequest = ~gntA and b_waitrequest = ~gntB. Both are high during reset, during freeze, and when the port is idle.
- Mode 0 (round-robin):
  - A single requester always wins.
  - If both request, the port not in last_gnt wins.
  - last_gnt updates on every grant.
- Mode 1 (fixed priority):
  - A wins when both request, unless consec_cnt == MAX_CONSEC; then B wins.
  - consec_cnt increments on an A grant while reqB is high.
  - consec_cnt clears on a B grant or when reqB is low. It saturates at MAX_CONSEC.
- Memory drive in the grant cycle:
  - mem_address and mem_writedata come from the winner.
  - mem_byteenable is 4'hF for A and b_byteenable for B.
  - mem_chipselect = gntA | gntB.
  - mem_write = gntB & b_write.
  - When idle, mem_address = a_address, mem_chipselect = 0, mem_write = 0.
- Read pipeline:
  - Registered flags rdv_a / rdv_b are set at edge N for a granted read and are high for exactly cycle N+1.
  - x_readdatavalid = rdv_x.
  - a_readdata = b_readdata = mem_readdata, passed through combinationally. Data is valid only when the matching readdatavalid is high.
- Throughput: back-to-back grants every cycle are allowed, with a read latency of 1. A write followed by a read of the same address on the next cycle returns the new data.
- Reset values (synchronous): last_gnt = B (so A wins first), consec_cnt = 0, rdv_a = 0, rdv_b = 0. Waitrequests are high while reset is high.
- Reset mid-operation: an in-flight read granted in the cycle where reset rises produces no readdatavalid.
- freeze mid-operation: a read granted in the previous cycle still completes its readdatavalid. No new grants are issued while freeze is high.
- Address wrap: addresses are modulo 2^ADDR_W and pass through unmodified.

Test Plan:
- Release reset, then A reads addr 0x005 with RAM preloaded 0x05 -> a_waitrequest low in the same cycle; a_readdatavalid=1 with a_readdata=0x00000005 exactly one cycle later; b_readdatavalid stays 0.
- Mode 0, A and B both read continuously for 6 cycles -> grant order A,B,A,B,A,B; each readdatavalid pulses the cycle after its own grant; mem_chipselect stays high all 6 cycles.
- B writes 0xDEADBEEF with byteenable 4'b0011 to addr 0x3FF, then A reads 0x3FF next cycle (word previously 0x11223344) -> a_readdata=0x1122BEEF.
- Mode 1, MAX_CONSEC=4, A and B requesting continuously -> pattern A,A,A,A,B repeating; consec_cnt reaches 4 and then clears on the B grant.
- B asserts b_read and b_write together, writing 0x0000CAFE to 0x010 -> mem_write=1 and b_readdatavalid never pulses; a later read of 0x010 returns 0x0000CAFE.
- A read granted in cycle N, then reset or freeze asserted at N+1:
  - Case reset rises in cycle N -> no a_readdatavalid.
  - Case freeze in N+1 -> a_readdatavalid in N+1, then both waitrequests high until freeze drops.
